bydin_rd_gen: RTL
=================

# bydin_rd_gen

Parametrised byte-deinterleaver read-side source model for the SPI data path. It walks a configurable rows×columns block in column-major or row-major order and returns one deterministic byte per accepted read after a fixed latency, derived from the generated RAM address. It also flags the last byte of each block, pulses a block-done interrupt, and emits a programmable periodic tick interrupt for firmware/bench pacing.

## Interface
- DATA_W, 8: output byte width
- ROW_W, 9: row counter width
- COL_W, 8: column counter width
- ADDR_W, 17: address width; must be ≥ 2·DATA_W
- STRIDE, 240: address step per row
- LAT, 3: rd_ena-to-rd_valid latency in clk cycles, ≥ 2
- TICK_DIV, 16: tick prescaler, power of two
- PER_W, 22: tick period counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches cfg_*, clears counters, sets busy
- cfg_rows  in  ROW_W  rows per block (M)
- cfg_cols  in  COL_W  columns per block (K)
- cfg_mode  in  1  0 = row index inner (column-major), 1 = column index inner (row-major)
- cfg_int_period  in  PER_W  tick period minus one, in prescaled ticks; sampled live
- rd_ena  in  1  read request, one byte per high cycle
- rd_data  out  DATA_W  returned byte
- rd_valid  out  1  rd_data valid
- rd_last  out  1  last byte of block, qualified by rd_valid
- busy  out  1  block in progress
- frame_int  out  1  one-cycle block-done pulse
- tick_int  out  1  one-cycle periodic pulse

## Operation
- All outputs reset to 0; all counters reset to 0.
- On start with cfg_rows ≠ 0 and cfg_cols ≠ 0: latch M, K, mode; set row = col = 0; busy = 1. Start with a zero dimension is ignored.
- Accepted read: rd_ena & busy & ~start. Reads while idle or in the start cycle are dropped and produce no output.
- Per accepted read: a = (row·STRIDE + col) mod 2^ADDR_W. Inner index advances, wrapping at M−1 (mode 0) or K−1 (mode 1). The outer index advances on inner wrap.
- Element (row = M−1, col = K−1) is the last. Its read clears busy and tags rd_last.
- rd_data = a[ADDR_W−1 : ADDR_W−DATA_W] ^ a[DATA_W−1 : 0].
- frame_int pulses in the same cycle as rd_valid & rd_last.
- Start while busy aborts the block. Counters restart with the new configuration. Reads already in the pipeline still emerge with their original data, and none of them carries rd_last.
- Tick: a free-running prescaler produces an enable every TICK_DIV clk cycles, and a period counter increments on each enable.
  - When the enable fires and period counter ≥ cfg_int_period: tick_int pulses for one clk cycle and the counter returns to 0.
  - Resulting period is (cfg_int_period+1)·TICK_DIV cycles.
  - Lowering cfg_int_period below the current count wraps on the next enable.
  - Single clock domain; no derived clocks.

## Timing
- rd_ena high during cycle N (sampled at edge N) → rd_valid, rd_data and rd_last high after edge N+LAT, all mutually aligned.
- Back-to-back reads give back-to-back valid bytes. Gaps in rd_ena appear unchanged at the output.
- busy falls at the edge that samples the last accepted read.
- The first tick_int comes (cfg_int_period+1)·TICK_DIV cycles after reset release.
- Reset mid-operation clears everything immediately; in-flight reads are lost.

## Structure
- Package bydin_pkg holds:
  - default parameter constants (240 stride, 288/224 reference dimensions)
  - the mode encoding
  - the data-pattern function (address → byte)
- Sub-module bydin_tick_gen holds the prescaler, period counter and tick_int.
- The top level holds counters, address stage, and the LAT-deep valid/last/data shift pipeline.

## Test plan
- Reset: hold reset_n low, drive rd_ena = 1 → all outputs stay 0; rd_ena while idle → no rd_valid.
- Mode 0 with M = 3, K = 2, continuous rd_ena → addresses 0, 240, 480, 1, 241, 481. Data 0x00, 0xF0, 0xE0, 0x01, 0xF1, 0xE1. rd_last and frame_int on the 6th byte. busy low afterwards.
- Mode 1 with M = 3, K = 2 → addresses 0, 1, 240, 241, 480, 481. Data 0x00, 0x01, 0xF0, 0xF1, 0xE0, 0xE1.
- Full block M = 288, K = 224, mode 0:
  - byte at row 287, col 0 (a = 0x10D10) → 0x96
  - exactly 64512 valid bytes, one rd_last
  - rd_ena toggled randomly → output gaps mirror the input with fixed LAT.
- Restart: start while busy after 4 reads → the 4 in-flight bytes emerge, then the new block starts from address 0, and no rd_last/frame_int is raised for the aborted block.
- Tick: TICK_DIV = 16, cfg_int_period = 3 → tick_int every 64 cycles, first at cycle 64. Changing the period to 0 mid-count → the next pulse within 16 cycles, then every 16.

Source files
------------

// File: rtl/bydin_pkg.sv
// Shared constants, walk-mode encoding and the address-to-byte data pattern
// for the byte-deinterleaver read-side source model.
package bydin_pkg;

  // Default address step per row and the reference block dimensions.
  localparam int DEF_STRIDE = 240;
  localparam int REF_ROWS   = 288;
  localparam int REF_COLS   = 224;

  // Widest address the pattern helper accepts.
  localparam int PAT_MAX_W = 64;

  // Walk order: which index is the inner (fast) one.
  typedef enum logic {
    MODE_COL_MAJOR = 1'b0,  // row index inner
    MODE_ROW_MAJOR = 1'b1   // column index inner
  } walk_mode_e;

  // Data byte = top data_w address bits XOR bottom data_w address bits.
  // The result is masked to data_w bits; callers truncate to their width.
  function automatic logic [PAT_MAX_W-1:0] addr_pattern(
    input logic [PAT_MAX_W-1:0] addr,
    input int                   addr_w,
    input int                   data_w
  );
    logic [PAT_MAX_W-1:0] mask;
    mask = (PAT_MAX_W'(1) << data_w) - PAT_MAX_W'(1);
    return ((addr >> (addr_w - data_w)) ^ addr) & mask;
  endfunction

endpackage

// File: rtl/bydin_tick_gen.sv
// Periodic tick interrupt: a free-running prescaler produces an enable every
// TICK_DIV cycles; a period counter advanced on that enable fires tick_int
// once it reaches the live cfg_int_period value.
module bydin_tick_gen #(
  parameter int TICK_DIV = 16,
  parameter int PER_W    = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [PER_W-1:0] cfg_int_period,
  output logic             tick_int
);

  localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0]  presc_q;
  logic [PER_W-1:0] per_q;
  logic             tick_en;

  assign tick_en = (presc_q == PS_LAST);

  // Free-running prescaler, restarted after each enable.
  // NOTE: state registers use non-blocking assignments and an async active-low
  // reset so every flop updates from pre-edge values and clears immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     presc_q <= '0;
    else if (tick_en) presc_q <= '0;
    else              presc_q <= presc_q + PS_W'(1);
  end

  // Period counter; >= (not ==) so a lowered period wraps on the next enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_q    <= '0;
      tick_int <= 1'b0;
    end else begin
      tick_int <= 1'b0;
      if (tick_en) begin
        if (per_q >= cfg_int_period) begin
          per_q    <= '0;
          tick_int <= 1'b1;
        end else begin
          per_q <= per_q + PER_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bydin_rd_gen.sv
// Read-side source model: walks a rows x cols block, returns one pattern byte
// per accepted read LAT cycles after the sampling edge, tags the last byte of
// the block and pulses frame_int with it.
module bydin_rd_gen
  import bydin_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ROW_W    = 9,
  parameter int COL_W    = 8,
  parameter int ADDR_W   = 17,
  parameter int STRIDE   = DEF_STRIDE,
  parameter int LAT      = 3,
  parameter int TICK_DIV = 16,
  parameter int PER_W    = 22
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [COL_W-1:0]  cfg_cols,
  input  logic              cfg_mode,
  input  logic [PER_W-1:0]  cfg_int_period,
  input  logic              rd_ena,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              frame_int,
  output logic              tick_int
);

  // Block configuration is held as last indices (M-1, K-1).
  logic [ROW_W-1:0]  row_max_q, row_q, row_nxt;
  logic [COL_W-1:0]  col_max_q, col_q, col_nxt;
  walk_mode_e        mode_q;
  logic              busy_q;
  logic              start_ok, accept, is_last;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              addr_vld_q, addr_last_q;
  logic [DATA_W-1:0] byte_d;
  logic [DATA_W-1:0] data_pipe [LAT];
  logic [LAT-1:0]    vld_pipe, last_pipe;

  assign start_ok = start & (cfg_rows != '0) & (cfg_cols != '0);
  assign accept   = rd_ena & busy_q & ~start;
  assign is_last  = (row_q == row_max_q) && (col_q == col_max_q);
  assign addr_d   = ADDR_W'(row_q) * ADDR_W'(STRIDE) + ADDR_W'(col_q);

  // Next walk position: inner index wraps and carries into the outer index.
  // NOTE: defaults first in always_comb so no path leaves a signal unassigned
  // (which would infer a latch).
  always_comb begin
    row_nxt = row_q;
    col_nxt = col_q;
    if (mode_q == MODE_COL_MAJOR) begin
      if (row_q == row_max_q) begin
        row_nxt = '0;
        col_nxt = (col_q == col_max_q) ? '0 : col_q + COL_W'(1);
      end else begin
        row_nxt = row_q + ROW_W'(1);
      end
    end else begin
      if (col_q == col_max_q) begin
        col_nxt = '0;
        row_nxt = (row_q == row_max_q) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_nxt = col_q + COL_W'(1);
      end
    end
  end

  // Configuration latch, walk counters and busy; start overrides any read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_max_q <= '0;
      col_max_q <= '0;
      mode_q    <= MODE_COL_MAJOR;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
    end else if (start_ok) begin
      row_max_q <= cfg_rows - ROW_W'(1);
      col_max_q <= cfg_cols - COL_W'(1);
      mode_q    <= walk_mode_e'(cfg_mode);
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b1;
    end else if (accept) begin
      row_q <= row_nxt;
      col_q <= col_nxt;
      if (is_last) busy_q <= 1'b0;
    end
  end

  // Address stage: captures the address of the read sampled at this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      addr_vld_q  <= 1'b0;
      addr_last_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      addr_vld_q  <= accept;
      addr_last_q <= accept & is_last;
    end
  end

  assign byte_d = DATA_W'(addr_pattern(PAT_MAX_W'(addr_q), ADDR_W, DATA_W));

  // LAT-deep output pipeline keeping data, valid and last aligned.
  // NOTE: the data stages are reset as well, because rd_data must read 0
  // out of reset rather than whatever the flops power up with.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      for (int i = 0; i < LAT; i++) data_pipe[i] <= '0;
    end else begin
      vld_pipe     <= {vld_pipe[LAT-2:0], addr_vld_q};
      last_pipe    <= {last_pipe[LAT-2:0], addr_last_q};
      data_pipe[0] <= byte_d;
      for (int i = 1; i < LAT; i++) data_pipe[i] <= data_pipe[i-1];
    end
  end

  assign rd_data   = data_pipe[LAT-1];
  assign rd_valid  = vld_pipe[LAT-1];
  assign rd_last   = last_pipe[LAT-1];
  assign frame_int = rd_valid & rd_last;
  assign busy      = busy_q;

  bydin_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PER_W    (PER_W)
  ) u_tick (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_int_period (cfg_int_period),
    .tick_int       (tick_int)
  );

endmodule
